// File: rtl/lcd_hex_frame_writer.sv
// HD44780 16x2 writer: one-time init, then endless refresh of a 64-bit word as
// two lines of 8 uppercase hex digits, each frame taken from a single snapshot.
module lcd_hex_frame_writer #(
    parameter int POWERUP_CYCLES    = 750000,
    parameter int E_HIGH_CYCLES     = 16,
    parameter int SETTLE_CYCLES     = 2000,
    parameter int CLEAR_WAIT_CYCLES = 82000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] value,
    output logic [7:0]  LCD_DATA,
    output logic        LCD_RS,
    output logic        LCD_RW,
    output logic        LCD_EN,
    output logic        init_done,
    output logic        frame_done
);
    typedef enum logic [2:0] {
        S_POWERUP,
        S_LOAD,
        S_SETUP,
        S_PULSE,
        S_WAIT
    } state_t;

    localparam logic [31:0] PU_T = 32'(POWERUP_CYCLES);
    localparam logic [31:0] E_T  = 32'(E_HIGH_CYCLES - 1);
    localparam logic [31:0] S_T  = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] C_T  = 32'(CLEAR_WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [4:0]  idx_q, idx_d;
    logic [63:0] snap_q, snap_d;
    logic [7:0]  data_q, data_d;
    logic        rs_q, rs_d;
    logic        en_q, en_d;
    logic        init_done_q, init_done_d;
    logic        frame_done_q, frame_done_d;

    logic [31:0] line_word;
    logic [2:0]  pos;
    logic [4:0]  nib_hi;
    logic [3:0]  nib;
    logic [7:0]  sel_byte;
    logic        sel_rs;
    logic [31:0] wait_t;

    // Character slots: idx 5..12 walk line 1, idx 14..21 walk line 2, MSB nibble first.
    always_comb begin
        line_word = (idx_q <= 5'd12) ? snap_q[63:32] : snap_q[31:0];
        pos       = (idx_q <= 5'd12) ? 3'(idx_q - 5'd5) : 3'(idx_q - 5'd14);
        nib_hi    = 5'd31 - {pos, 2'b00};
        nib       = line_word[nib_hi -: 4];
        sel_rs    = 1'b0;
        case (idx_q)
            5'd0:    sel_byte = 8'h38;
            5'd1:    sel_byte = 8'h0C;
            5'd2:    sel_byte = 8'h01;
            5'd3:    sel_byte = 8'h06;
            5'd4:    sel_byte = 8'h80;
            5'd13:   sel_byte = 8'hC0;
            default: begin
                sel_rs   = 1'b1;
                sel_byte = (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
            end
        endcase
    end

    assign wait_t = (idx_q == 5'd2) ? C_T : S_T;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        snap_d       = snap_q;
        data_d       = data_q;
        rs_d         = rs_q;
        en_d         = en_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_POWERUP: begin
                if (cnt_q == PU_T) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_LOAD: begin
                data_d  = sel_byte;
                rs_d    = sel_rs;
                state_d = S_SETUP;
                if (idx_q == 5'd4) snap_d = value;
            end
            S_SETUP: begin
                en_d    = 1'b1;
                cnt_d   = '0;
                state_d = S_PULSE;
            end
            S_PULSE: begin
                if (cnt_q == E_T) begin
                    en_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_WAIT: begin
                if (cnt_q == wait_t) begin
                    cnt_d   = '0;
                    state_d = S_LOAD;
                    if (idx_q == 5'd3) init_done_d = 1'b1;
                    // Line 2's last digit closes the frame; init is never revisited.
                    if (idx_q == 5'd21) begin
                        idx_d        = 5'd4;
                        frame_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = S_POWERUP;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_POWERUP;
            cnt_q        <= '0;
            idx_q        <= '0;
            snap_q       <= '0;
            data_q       <= '0;
            rs_q         <= 1'b0;
            en_q         <= 1'b0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            data_q       <= data_d;
            rs_q         <= rs_d;
            en_q         <= en_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign LCD_DATA   = data_q;
    assign LCD_RS     = rs_q;
    assign LCD_RW     = 1'b0;
    assign LCD_EN     = en_q;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;
endmodule
